// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: FSM encoding, sizing constants and index helper shared by bus_arbiter.
package bus_arb_pkg;
   localparam int MAX_MASTERS = 4;
   localparam int HOLD_W = 16;
   typedef enum logic [1:0] {IDLE, OWNED, TURNAROUND} state_t;
   function automatic logic [1:0] oh2idx(input logic [MAX_MASTERS-1:0] oh);
      oh2idx = {oh[3] | oh[2], oh[3] | oh[1]};
   endfunction
endpackage

// File: rtl/bus_arb_picker.sv
// bus_arb_picker: combinational one-hot winner selection for bus_arbiter.
// BUS_ARB_FIXED_PRIO_EN selects lowest-index priority; otherwise round-robin after last_owner.
module bus_arb_picker import bus_arb_pkg::*; #(
   parameter int NUM_MASTERS = 2
) (
   input  logic [NUM_MASTERS-1:0] req,
   input  logic [1:0]             last_owner,
   output logic [NUM_MASTERS-1:0] winner
);
   localparam logic [NUM_MASTERS-1:0] ONE = 1;
   logic [NUM_MASTERS-1:0] lo_mask, above, pool;
   assign lo_mask = (ONE << last_owner) | ((ONE << last_owner) - ONE);
   assign above = req & ~lo_mask;
`ifdef BUS_ARB_FIXED_PRIO_EN
   assign pool = req;
`else
   // masters after last_owner first, wrapping to the full request set
   assign pool = |above ? above : req;
`endif
   assign winner = pool & (~pool + ONE);
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: IDLE/OWNED/TURNAROUND bus arbiter with sticky hold-limit violation flag.
// Define BUS_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module bus_arbiter import bus_arb_pkg::*; #(
   parameter int NUM_MASTERS = 2,
   parameter int HOLD_LIMIT = 256
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_MASTERS-1:0] req,
   output logic [NUM_MASTERS-1:0] grant,
   output logic                   bus_busy,
   output logic [1:0]             owner,
   output logic                   hold_err,
   input  logic                   hold_err_clr
);
   localparam logic [HOLD_W-1:0] LIMIT = HOLD_W'(HOLD_LIMIT);
   state_t state, nxt;
   logic [1:0] last_owner, win_idx;
   logic [NUM_MASTERS-1:0] winner;
   logic [HOLD_W-1:0] hold_cnt, hold_inc;
   logic own_req, others, decide, err_set;

   bus_arb_picker #(.NUM_MASTERS(NUM_MASTERS)) u_picker (
      .req(req),
      .last_owner(last_owner),
      .winner(winner)
   );

   always_comb begin
      own_req = |(req & grant);
      others = |(req & ~grant);
      decide = state != OWNED && |req;
      win_idx = oh2idx(MAX_MASTERS'(winner));
      hold_inc = hold_cnt == LIMIT ? hold_cnt : hold_cnt + HOLD_W'(1);
      // flag raised on the edge that completes the HOLD_LIMIT-th owned cycle
      err_set = state == OWNED && LIMIT != '0 && hold_inc == LIMIT && others;
      nxt = state == OWNED ? (own_req ? OWNED : TURNAROUND) : (|req ? OWNED : IDLE);
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= IDLE;
         grant <= '0;
         bus_busy <= 1'b0;
         owner <= 2'd0;
         last_owner <= 2'(NUM_MASTERS - 1);
         hold_cnt <= '0;
         hold_err <= 1'b0;
      end else begin
         state <= nxt;
         bus_busy <= nxt == OWNED;
         hold_err <= err_set | (hold_err & ~hold_err_clr);
         if (decide) begin
            grant <= winner;
            owner <= win_idx;
            last_owner <= win_idx;
            hold_cnt <= '0;
         end else if (state == OWNED) begin
            hold_cnt <= hold_inc;
            if (!own_req) grant <= '0;
         end
      end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed stimulus with a cycle-tagged scoreboard checked at every falling edge.
module tb_bus_arbiter;
   typedef struct {
      int cyc;
      string name;
      logic [1:0] g;
      logic busy;
      logic [1:0] own;
      logic err;
   } exp_t;

   logic clk, rst, hold_err_clr, bus_busy, hold_err;
   logic [1:0] req, grant, owner;
   exp_t q[$];
   exp_t e;
   int cyc = 0;
   int tests = 0;
   int failed = 0;

   bus_arbiter #(.NUM_MASTERS(2), .HOLD_LIMIT(4)) dut (
      .clk(clk),
      .rst(rst),
      .req(req),
      .grant(grant),
      .bus_busy(bus_busy),
      .owner(owner),
      .hold_err(hold_err),
      .hold_err_clr(hold_err_clr)
   );

`ifdef BUS_ARB_FIXED_PRIO_EN
   localparam logic [1:0] C_G = 2'b01;
   localparam logic [1:0] C_O = 2'd0;
`else
   localparam logic [1:0] C_G = 2'b10;
   localparam logic [1:0] C_O = 2'd1;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk)
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         e = q.pop_front();
         tests++;
         if (e.cyc != cyc || grant !== e.g || bus_busy !== e.busy || owner !== e.own || hold_err !== e.err) begin
            failed++;
            $display("FAIL %s: cyc=%0d grant=%b busy=%b owner=%0d hold_err=%b, expected cyc=%0d grant=%b busy=%b owner=%0d hold_err=%b",
                     e.name, cyc, grant, bus_busy, owner, hold_err, e.cyc, e.g, e.busy, e.own, e.err);
         end
      end

   task automatic chk(input int dc, input logic [1:0] g, input logic b, input logic [1:0] o, input logic er, input string n);
      q.push_back('{cyc: cyc + dc, name: n, g: g, busy: b, own: o, err: er});
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d checks pending", q.size());
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      req = 2'b00;
      hold_err_clr = 1'b0;
      step(1);
      chk(0, 2'b00, 0, 0, 0, "reset");
      rst = 1'b1;
      req = 2'b01;
      chk(0, 2'b00, 0, 0, 0, "latency");
      chk(1, 2'b01, 1, 0, 0, "first_grant");
      step(1);
      req = 2'b00;
      chk(1, 2'b00, 0, 0, 0, "release_turn");
      chk(2, 2'b00, 0, 0, 0, "release_idle");
      step(2);
      rst = 1'b0;
      step(1);
      rst = 1'b1;
      req = 2'b11;
      chk(1, 2'b01, 1, 0, 0, "rr_m0");
      step(1);
      req = 2'b10;
      chk(1, 2'b00, 0, 0, 0, "rr_turn");
      chk(2, 2'b10, 1, 1, 0, "rr_m1");
      step(2);
      req = 2'b01;
      chk(1, 2'b00, 0, 1, 0, "rr_turn2");
      chk(2, 2'b01, 1, 0, 0, "rr_m0_again");
      step(2);
      req = 2'b10;
      chk(1, 2'b00, 0, 0, 0, "c_turn");
      step(1);
      req = 2'b11;
      chk(1, C_G, 1, C_O, 0, "c_win");
      step(1);
      req = 2'b00;
      chk(1, 2'b00, 0, C_O, 0, "c_turn2");
      step(2);
      req = 2'b01;
      chk(1, 2'b01, 1, 0, 0, "h_grant");
      step(1);
      req = 2'b11;
      chk(3, 2'b01, 1, 0, 0, "h_before");
      chk(4, 2'b01, 1, 0, 1, "h_err");
      step(6);
      hold_err_clr = 1'b1;
      chk(1, 2'b01, 1, 0, 1, "h_set_wins");
      step(1);
      hold_err_clr = 1'b0;
      chk(3, 2'b01, 1, 0, 1, "h_grant_kept");
      step(3);
      req = 2'b10;
      chk(1, 2'b00, 0, 0, 1, "h_turn");
      chk(2, 2'b10, 1, 1, 1, "h_m1");
      step(2);
      hold_err_clr = 1'b1;
      chk(1, 2'b10, 1, 1, 0, "h_clr");
      step(1);
      hold_err_clr = 1'b0;
      req = 2'b00;
      step(2);
      req = 2'b10;
      chk(1, 2'b10, 1, 1, 0, "r_own");
      step(2);
      rst = 1'b0;
      chk(0, 2'b00, 0, 0, 0, "r_async");
      step(1);
      chk(0, 2'b00, 0, 0, 0, "r_held");
      rst = 1'b1;
      chk(1, 2'b10, 1, 1, 0, "r_regrant");
      step(1);
      req = 2'b00;
      step(2);
      req = 2'b01;
      chk(1, 2'b01, 1, 0, 0, "p_m0");
      step(1);
      req = 2'b11;
      step(1);
      req = 2'b01;
      chk(1, 2'b01, 1, 0, 0, "p_ignored");
      step(1);
      req = 2'b00;
      chk(1, 2'b00, 0, 0, 0, "p_turn");
      chk(2, 2'b00, 0, 0, 0, "p_idle");
      chk(3, 2'b00, 0, 0, 0, "p_never");
      step(4);
      if (q.size() != 0) begin
         failed++;
         $display("FAIL drain: %0d checks left unevaluated, expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- NUM_MASTERS, default 2, number of bus masters (legal range 2..4).
- HOLD_LIMIT, default 256, maximum OWNED cycles before a hold violation is flagged while others wait (0 disables checking).
REQ-002 Ports SHALL be, one per line:
- clk  in  1  system clock.
- rst  in  1  reset.
- req  in  NUM_MASTERS  per-master bus_req.
- grant  out  NUM_MASTERS  per-master bus_grant, one-hot or zero.
- bus_busy  out  1  high while any grant is asserted.
- owner  out  2  index of the current or last granted master.
- hold_err  out  1  sticky hold-limit violation flag.
- hold_err_clr  in  1  clears hold_err.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-004 FSM states SHALL be IDLE, OWNED and TURNAROUND; all outputs are registered.
REQ-005 In IDLE, if any req bit is sampled high at a clk edge, grant SHALL go one-hot to the winner at that edge and the state SHALL become OWNED. Latency is 1 cycle from req high to grant high.
REQ-006 In OWNED, grant SHALL hold while req[owner] stays high, regardless of other requests.
REQ-007 When req[owner] is sampled low, grant SHALL clear at that edge and the state SHALL become TURNAROUND.
REQ-008 TURNAROUND SHALL last exactly one cycle with grant all-zero (bus tri-state handover).
REQ-009 At the end of TURNAROUND, a pending request SHALL be granted directly (to OWNED); otherwise the state SHALL become IDLE.
REQ-010 Round-robin: the search SHALL start at (last_owner+1) mod NUM_MASTERS. last_owner updates on every new grant.
REQ-011 req bits SHALL be sampled only at decision edges. A request withdrawn before a decision edge SHALL NOT be granted.
REQ-012 owner SHALL update on each new grant and retain its value in IDLE and TURNAROUND.
REQ-013 Hold counter: 16 bits. It SHALL clear on each new grant, increment each OWNED cycle and saturate at HOLD_LIMIT.
REQ-014 hold_err SHALL set at the edge where the counter equals HOLD_LIMIT and any non-owner req is high. If set and hold_err_clr occur in the same cycle, set SHALL win.
REQ-015 hold_err_clr SHALL clear hold_err at the next edge. Violation checking SHALL NOT revoke the grant.
REQ-016 req bits at index >= NUM_MASTERS do not exist. The back-to-back release-to-regrant minimum SHALL be 2 cycles.

Reset
REQ-017 rst low SHALL immediately force the state to IDLE and clear grant, bus_busy, owner, hold_err and the hold counter, including mid-ownership.
REQ-018 Reset SHALL set last_owner to NUM_MASTERS-1 so that master 0 wins the first contention.
REQ-019 The first decision edge SHALL be the first rising clk edge after rst deasserts.

Configuration
REQ-020 Macro BUS_ARB_FIXED_PRIO_EN defined: the lowest-index requester SHALL always win and last_owner is unused.
REQ-021 Macro BUS_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-010.

Structure
REQ-022 Package bus_arb_pkg SHALL hold the FSM state encodings, the MAX_MASTERS=4 constant and the hold-counter width.
REQ-023 Sub-module bus_arb_picker SHALL contain the purely combinational winner selection (inputs req and last_owner; output a one-hot winner). bus_arbiter SHALL hold all state.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset; req=01 -> grant=01 one cycle later, owner=0, bus_busy=1.
- req=11 held after reset -> grant 01; drop req[0] -> one zero-grant cycle, then grant=10 (round-robin). Repeat -> master 0 next.
- BUS_ARB_FIXED_PRIO_EN, req=11 continuously re-requested -> master 0 always wins.
- HOLD_LIMIT=4, master 0 holds 10 cycles with req[1] high -> hold_err=1 at OWNED cycle 4, grant unchanged. Pulse hold_err_clr -> hold_err=0.
- rst low mid-OWNED -> grant=00 immediately (no edge). After release, req=10 -> grant=10 one cycle later.
- req[1] pulses for one cycle while master 0 owns -> never granted. Release of master 0 -> IDLE.
